// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder reusing one full adder, LSB first, valid/ready on both sides

module fulladder (
    input  logic x,
    input  logic y,
    input  logic carry_in,
    output logic s,
    output logic carry_out
);
    assign s         = x ^ y ^ carry_in;
    assign carry_out = (x & y) | (x & carry_in) | (y & carry_in);
endmodule

module serial_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [WIDTH-1:0] res_next;
    logic [CNT_W-1:0] cnt;
    logic             carry;
    logic             s_fadd;
    logic             carry_out;

    fulladder u_fadd (
        .x         (a_sr[0]),
        .y         (b_sr[0]),
        .carry_in  (carry),
        .s         (s_fadd),
        .carry_out (carry_out)
    );

    // Each new bit enters at the MSB so bit 0 lands at position 0 after WIDTH shifts.
    assign res_next  = {s_fadd, res_sr[WIDTH-1:1]};
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    res_sr <= res_next;
                    a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
                    carry  <= carry_out;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        sum   <= res_next;
                        cout  <= carry_out;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that computes `a + b + cin` over WIDTH clock cycles by time-multiplexing a single `fulladder` instance, one bit per cycle, LSB first. It sits between an operand producer and a result consumer, each on a valid/ready handshake. It trades latency for area against the parallel 4-bit ripple adder.

## Interface
- `WIDTH`, default 4: operand and sum width in bits; legal range 2 to 32.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: the producer presents `a`, `b` and `cin`.
- `in_ready`  out  1: the block accepts operands; high only in IDLE.
- `a`  in  WIDTH: addend A, sampled on the accept edge only.
- `b`  in  WIDTH: addend B, sampled on the accept edge only.
- `cin`  in  1: carry into bit 0, sampled on the accept edge only.
- `out_valid`  out  1: `sum` and `cout` hold a completed result; high only in DONE.
- `out_ready`  in  1: the consumer takes the result.
- `sum`  out  WIDTH: registered result `(a+b+cin) mod 2^WIDTH`.
- `cout`  out  1: registered carry out of bit WIDTH-1.

## Operation
- Exactly one `fulladder` instance performs all arithmetic:
  - `x` = LSB of the A shift register.
  - `y` = LSB of the B shift register.
  - `carry_in` = the carry flop.
- Internal state: A and B shift registers (WIDTH each), a result shift register (WIDTH), a carry flop, a bit counter (clog2(WIDTH) bits), and a 2-bit state.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`=1, load A←`a`, B←`b`, carry←`cin`, counter←0, then go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT, each cycle:
  - Result register shifts right, taking `s_fadd` into its MSB.
  - A and B shift right, zero-filled.
  - Carry ← `carry_out`.
  - Counter increments.
  - On the cycle where the counter = WIDTH-1: load `sum` ← final result value (including this cycle's bit), load `cout` ← `carry_out`, then go to DONE.
- DONE:
  - `out_valid`=1, with `sum` and `cout` stable.
  - On `out_ready`=1, go to IDLE; otherwise hold indefinitely.
- `in_valid` outside IDLE is ignored. `a`, `b` and `cin` are don't-care outside the accept edge.
- `sum` and `cout` change only on the edge entering DONE. They keep the last result through IDLE and SHIFT until the next completion.
- `out_ready` outside DONE is ignored.

## Timing
- `in_ready` and `out_valid` are decoded combinationally from the state register only, with no input-to-output combinational path.
- Accept edge T is an edge where `in_valid`=1 and the state is IDLE.
  - SHIFT processes bits on edges T+1 … T+WIDTH.
  - `out_valid` rises after edge T+WIDTH, so latency is WIDTH cycles.
- Release edge R is an edge where `out_valid`=1 and `out_ready`=1.
  - IDLE is entered at R.
  - The earliest next accept is edge R+1.
  - Maximum throughput is one operation per WIDTH+2 cycles.
- Reset (`rst`=1 at an edge):
  - State → IDLE; `sum`, `cout`, carry, counter and shift registers → 0.
  - After reset: `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
- Reset wins over every other event at the same edge, including an accept or a release.
- Reset mid-SHIFT aborts the operation; no `out_valid` is produced for it.
- Carry chain wrap-around: the carry out of bit WIDTH-1 goes only to `cout`. It is never fed back to bit 0.

## Test plan
- Reset: hold `rst` for 2 cycles → `in_ready`=1, `out_valid`=0, `sum`=0, `cout`=0.
- WIDTH=4, `a`=0101, `b`=0011, `cin`=0, `out_ready`=1:
  - Response: `sum`=1000, `cout`=0.
  - `out_valid` rises exactly 4 edges after accept and falls 1 edge later.
- `a`=1111, `b`=0001, `cin`=0 → `sum`=0000, `cout`=1.
- `a`=1111, `b`=1111, `cin`=1 → `sum`=1111, `cout`=1.
- Backpressure and busy behaviour:
  - Hold `out_ready`=0 for 5 cycles in DONE → `sum` and `cout` stay stable and `out_valid` stays 1.
  - Drive `in_valid`=1 with new operands during SHIFT and DONE → ignored, and the result is unchanged.
- Reset and back-to-back operation:
  - Assert `rst` on the 2nd SHIFT cycle of 0111+0001 → no `out_valid`.
  - Next operation 0010+0010, `cin`=1 → `sum`=0101, `cout`=0.
  - Back-to-back operations with `in_valid` and `out_ready` tied high → accepts spaced exactly 6 edges apart.
